// File: rtl/store_unit_lite.sv
// Store stage: MMU handshake, speculative queue, commit queue and D$ write port.
// Enqueue in the TLB-hit cycle with writeback one cycle later; stalls on TLB miss or a full speculative queue.
module store_unit_lite #(
  parameter int unsigned DEPTH_SPEC   = 4,
  parameter int unsigned DEPTH_COMMIT = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         valid_i,
  input  logic [84:0]  lsu_ctrl_i,
  output logic         pop_st_o,
  input  logic         commit_i,
  output logic         commit_ready_o,
  input  logic         amo_valid_commit_i,
  output logic         valid_o,
  output logic [2:0]   trans_id_o,
  output logic [31:0]  result_o,
  output logic [64:0]  ex_o,
  output logic         translation_req_o,
  output logic [31:0]  vaddr_o,
  input  logic [33:0]  paddr_i,
  input  logic [64:0]  ex_i,
  input  logic         dtlb_hit_i,
  input  logic [11:0]  page_offset_i,
  output logic         page_offset_matches_o,
  output logic         no_st_pending_o,
  output logic         store_buffer_empty_o,
  output logic [134:0] amo_req_o,
  input  logic [64:0]  amo_resp_i,
  input  logic [34:0]  req_port_i,
  output logic [76:0]  req_port_o
);

  typedef struct packed {
    logic        valid;
    logic [31:0] vaddr;
    logic        overflow;
    logic [31:0] data;
    logic [3:0]  be;
    logic [3:0]  fu;
    logic [7:0]  op;
    logic [2:0]  trans_id;
  } lsu_ctrl_t;

  typedef struct packed {
    logic [31:0] cause;
    logic [31:0] tval;
    logic        valid;
  } exc_t;

  typedef struct packed {
    logic [33:0] paddr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [1:0]  size;
  } st_entry_t;

  typedef enum logic [1:0] {IDLE, VALID_STORE, WAIT_TRANSLATION, WAIT_STORE_READY} state_t;

  localparam int unsigned SPW = (DEPTH_SPEC > 1) ? $clog2(DEPTH_SPEC) : 1;
  localparam int unsigned SPC = $clog2(DEPTH_SPEC + 1);
  localparam int unsigned CMW = (DEPTH_COMMIT > 1) ? $clog2(DEPTH_COMMIT) : 1;
  localparam int unsigned CMC = $clog2(DEPTH_COMMIT + 1);

  state_t    state_q;
  lsu_ctrl_t lsu_ctrl, req_q, cur;
  exc_t      ex_in, ex_q;
  logic      valid_q;
  logic [2:0] tid_q;

  logic waiting, accept, pending, ex_hit, done;
  logic spec_full, spec_empty, com_full, com_empty;
  logic data_gnt, gnt_pop, commit_go, match;
  logic [1:0]  size;
  logic [63:0] data_dbl;
  st_entry_t   new_entry, head;

  st_entry_t             spec_mem [DEPTH_SPEC];
  logic [DEPTH_SPEC-1:0] spec_vld;
  logic [SPW-1:0]        spec_wr, spec_rd;
  logic [SPC-1:0]        spec_cnt;

  st_entry_t               com_mem [DEPTH_COMMIT];
  logic [DEPTH_COMMIT-1:0] com_vld;
  logic [CMW-1:0]          com_wr, com_rd;
  logic [CMC-1:0]          com_cnt;

  assign lsu_ctrl = lsu_ctrl_i;
  assign ex_in    = ex_i;
  assign data_gnt = req_port_i[34];

  // In the wait states the latched request is replayed; otherwise the live input is the request.
  assign waiting = (state_q == WAIT_TRANSLATION) || (state_q == WAIT_STORE_READY);
  assign accept  = valid_i && !waiting;
  assign pending = waiting || accept;
  assign cur     = waiting ? req_q : lsu_ctrl;

  assign spec_full  = (spec_cnt == SPC'(DEPTH_SPEC));
  assign spec_empty = (spec_cnt == '0);
  assign com_full   = (com_cnt == CMC'(DEPTH_COMMIT));
  assign com_empty  = (com_cnt == '0);

  assign ex_hit = pending && ex_in.valid && !flush_i;
  assign done   = pending && !ex_in.valid && dtlb_hit_i && !spec_full && !flush_i;

  assign gnt_pop        = !com_empty && data_gnt;
  assign commit_ready_o = !com_full || gnt_pop;
  assign commit_go      = commit_i && !spec_empty && commit_ready_o && !flush_i;

  always_comb begin
    case (cur.op)
      8'd42:   size = 2'd1;
      8'd44:   size = 2'd0;
      default: size = 2'd2;
    endcase
  end

  assign data_dbl  = {cur.data, cur.data} << {cur.vaddr[1:0], 3'b000};
  assign new_entry = '{paddr: paddr_i, data: data_dbl[63:32], be: cur.be, size: size};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= '0;
      valid_q <= 1'b0;
      tid_q   <= '0;
      ex_q    <= '0;
    end else begin
      if (accept) req_q <= lsu_ctrl;
      valid_q <= done || ex_hit;
      ex_q    <= ex_hit ? ex_in : '0;
      if (done || ex_hit) tid_q <= cur.trans_id;
      if (flush_i)                     state_q <= IDLE;
      else if (done || ex_hit)         state_q <= VALID_STORE;
      else if (pending && !dtlb_hit_i) state_q <= WAIT_TRANSLATION;
      else if (pending)                state_q <= WAIT_STORE_READY;
      else                             state_q <= IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (done) spec_mem[spec_wr] <= new_entry;
    if (commit_go) com_mem[com_wr] <= spec_mem[spec_rd];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      spec_wr  <= '0;
      spec_rd  <= '0;
      spec_cnt <= '0;
      spec_vld <= '0;
    end else begin
      if (done) begin
        spec_vld[spec_wr] <= 1'b1;
        spec_wr <= (spec_wr == SPW'(DEPTH_SPEC - 1)) ? '0 : spec_wr + SPW'(1);
      end
      if (commit_go) begin
        spec_vld[spec_rd] <= 1'b0;
        spec_rd <= (spec_rd == SPW'(DEPTH_SPEC - 1)) ? '0 : spec_rd + SPW'(1);
      end
      case ({done, commit_go})
        2'b10:   spec_cnt <= spec_cnt + SPC'(1);
        2'b01:   spec_cnt <= spec_cnt - SPC'(1);
        default: spec_cnt <= spec_cnt;
      endcase
    end
  end

  // Pop is applied before push so a full queue pushing and popping the same slot keeps it valid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      com_wr  <= '0;
      com_rd  <= '0;
      com_cnt <= '0;
      com_vld <= '0;
    end else begin
      if (gnt_pop) begin
        com_vld[com_rd] <= 1'b0;
        com_rd <= (com_rd == CMW'(DEPTH_COMMIT - 1)) ? '0 : com_rd + CMW'(1);
      end
      if (commit_go) begin
        com_vld[com_wr] <= 1'b1;
        com_wr <= (com_wr == CMW'(DEPTH_COMMIT - 1)) ? '0 : com_wr + CMW'(1);
      end
      case ({commit_go, gnt_pop})
        2'b10:   com_cnt <= com_cnt + CMC'(1);
        2'b01:   com_cnt <= com_cnt - CMC'(1);
        default: com_cnt <= com_cnt;
      endcase
    end
  end

  always_comb begin
    match = 1'b0;
    for (int i = 0; i < int'(DEPTH_SPEC); i++)
      if (spec_vld[i] && (spec_mem[i].paddr[11:2] == page_offset_i[11:2])) match = 1'b1;
    for (int i = 0; i < int'(DEPTH_COMMIT); i++)
      if (com_vld[i] && (com_mem[i].paddr[11:2] == page_offset_i[11:2])) match = 1'b1;
  end

  assign head = com_mem[com_rd];

  always_comb begin
    req_port_o = '0;
    if (!com_empty)
      req_port_o = {head.paddr[11:0], head.paddr[33:12], head.data, 1'b0, 1'b1, 1'b1,
                    head.be, head.size, 1'b0, 1'b0};
  end

  assign pop_st_o              = done || ex_hit;
  assign translation_req_o     = pending;
  assign vaddr_o               = cur.vaddr;
  assign valid_o               = valid_q;
  assign trans_id_o            = tid_q;
  assign result_o              = '0;
  assign ex_o                  = ex_q;
  assign amo_req_o             = '0;
  assign page_offset_matches_o = match;
  assign no_st_pending_o       = com_empty;
  assign store_buffer_empty_o  = spec_empty && com_empty;

  logic unused_ok;
  assign unused_ok = ^{amo_valid_commit_i, amo_resp_i, req_port_i[33:0], cur.valid,
                       cur.overflow, cur.fu, data_dbl[31:0]};

endmodule

// File: tb/tb_store_unit_lite.sv
// Directed scenarios followed by random traffic, all checked against a queue-based reference model.
module tb_store_unit_lite;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_i, flush_i, valid_i, commit_i, amo_valid_commit_i, dtlb_hit_i;
  logic [84:0]  lsu_ctrl_i;
  logic         pop_st_o, commit_ready_o, valid_o, translation_req_o;
  logic [2:0]   trans_id_o;
  logic [31:0]  result_o, vaddr_o;
  logic [64:0]  ex_o, ex_i, amo_resp_i;
  logic [33:0]  paddr_i;
  logic [11:0]  page_offset_i;
  logic         page_offset_matches_o, no_st_pending_o, store_buffer_empty_o;
  logic [134:0] amo_req_o;
  logic [34:0]  req_port_i;
  logic [76:0]  req_port_o;

  store_unit_lite dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .lsu_ctrl_i(lsu_ctrl_i),
    .pop_st_o(pop_st_o), .commit_i(commit_i), .commit_ready_o(commit_ready_o),
    .amo_valid_commit_i(amo_valid_commit_i), .valid_o(valid_o), .trans_id_o(trans_id_o),
    .result_o(result_o), .ex_o(ex_o), .translation_req_o(translation_req_o), .vaddr_o(vaddr_o),
    .paddr_i(paddr_i), .ex_i(ex_i), .dtlb_hit_i(dtlb_hit_i), .page_offset_i(page_offset_i),
    .page_offset_matches_o(page_offset_matches_o), .no_st_pending_o(no_st_pending_o),
    .store_buffer_empty_o(store_buffer_empty_o), .amo_req_o(amo_req_o), .amo_resp_i(amo_resp_i),
    .req_port_i(req_port_i), .req_port_o(req_port_o)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [33:0] paddr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [1:0]  size;
  } ent_t;

  ent_t        m_spec[$];
  ent_t        m_com[$];
  logic        m_wait  = 1'b0;
  logic [84:0] m_req   = '0;
  logic        m_valid = 1'b0;
  logic [2:0]  m_tid   = '0;
  logic [64:0] m_ex    = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [84:0] mk_lsu(input logic [31:0] va, input logic [31:0] d,
                                         input logic [3:0] be, input logic [7:0] op,
                                         input logic [2:0] id);
    return {1'b1, va, 1'b0, d, be, 4'd1, op, id};
  endfunction

  function automatic logic [31:0] rotl_bytes(input logic [31:0] d, input logic [1:0] k);
    logic [31:0] r = d;
    for (int i = 0; i < int'(k); i++) r = {r[23:0], r[31:24]};
    return r;
  endfunction

  function automatic logic [1:0] op_size(input logic [7:0] op);
    if (op == 8'd42) return 2'd1;
    if (op == 8'd44) return 2'd0;
    return 2'd2;
  endfunction

  // One clock: compare every output against the model mid-cycle, then advance model and DUT.
  task automatic tick();
    logic [84:0] cur;
    logic accept, pending, exc, done, gpop, cready, cmt, match;
    ent_t e;
    #3;
    accept  = valid_i && !m_wait;
    pending = m_wait || accept;
    cur     = m_wait ? m_req : lsu_ctrl_i;
    exc     = pending && ex_i[0] && !flush_i;
    done    = pending && !ex_i[0] && dtlb_hit_i && (m_spec.size() < 4) && !flush_i;
    gpop    = (m_com.size() > 0) && req_port_i[34];
    cready  = (m_com.size() < 8) || gpop;
    cmt     = commit_i && (m_spec.size() > 0) && cready && !flush_i;
    match   = 1'b0;
    foreach (m_spec[i]) if (m_spec[i].paddr[11:2] == page_offset_i[11:2]) match = 1'b1;
    foreach (m_com[i])  if (m_com[i].paddr[11:2] == page_offset_i[11:2]) match = 1'b1;

    chk("pop_st", pop_st_o, exc || done);
    chk("translation_req", translation_req_o, pending);
    chk("vaddr", vaddr_o, cur[83:52]);
    chk("commit_ready", commit_ready_o, cready);
    chk("valid", valid_o, m_valid);
    if (m_valid) chk("trans_id", trans_id_o, m_tid);
    chk("ex", ex_o, m_ex);
    chk("result", result_o, 0);
    chk("amo_req", amo_req_o, 0);
    chk("page_match", page_offset_matches_o, match);
    chk("no_st_pending", no_st_pending_o, m_com.size() == 0);
    chk("sb_empty", store_buffer_empty_o, (m_com.size() == 0) && (m_spec.size() == 0));
    if (m_com.size() == 0) begin
      chk("port_idle", req_port_o, 0);
    end else begin
      e = m_com[0];
      chk("port_index", req_port_o[76:65], e.paddr[11:0]);
      chk("port_tag", req_port_o[64:43], e.paddr[33:12]);
      chk("port_wdata", req_port_o[42:11], e.data);
      chk("port_ctl", {req_port_o[10:8], req_port_o[1:0]}, 5'b01100);
      chk("port_be", req_port_o[7:4], e.be);
      chk("port_size", req_port_o[3:2], e.size);
    end

    @(posedge clk);
    if (rst_i) begin
      m_spec.delete(); m_com.delete();
      m_wait = 1'b0; m_req = '0; m_valid = 1'b0; m_tid = '0; m_ex = '0;
    end else begin
      if (gpop) void'(m_com.pop_front());
      if (cmt) m_com.push_back(m_spec.pop_front());
      if (done) begin
        e.paddr = paddr_i;
        e.data  = rotl_bytes(cur[50:19], cur[53:52]);
        e.be    = cur[18:15];
        e.size  = op_size(cur[10:3]);
        m_spec.push_back(e);
      end
      if (flush_i) m_spec.delete();
      if (accept) m_req = lsu_ctrl_i;
      m_wait  = !flush_i && pending && !done && !exc;
      m_valid = done || exc;
      if (done || exc) m_tid = cur[2:0];
      m_ex = exc ? ex_i : '0;
    end
    #1;
  endtask

  initial begin
    logic [7:0] ops [4];
    ops[0] = 8'd39; ops[1] = 8'd42; ops[2] = 8'd44; ops[3] = 8'd7;
    rst_i = 1'b1; flush_i = 0; valid_i = 0; commit_i = 0; amo_valid_commit_i = 0;
    dtlb_hit_i = 0; lsu_ctrl_i = '0; ex_i = '0; amo_resp_i = '0; paddr_i = '0;
    page_offset_i = '0; req_port_i = '0;
    @(posedge clk); #1;

    // Reset values
    chk("rst_sb_empty", store_buffer_empty_o, 1);
    chk("rst_no_st_pending", no_st_pending_o, 1);
    chk("rst_commit_ready", commit_ready_o, 1);
    chk("rst_valid", valid_o, 0);
    chk("rst_port", req_port_o, 0);
    tick(); tick();
    rst_i = 1'b0;
    tick();

    // Store then commit then grant
    valid_i = 1; dtlb_hit_i = 1; paddr_i = 34'h012345679;
    lsu_ctrl_i = mk_lsu(32'h12345679, 32'hAABBCCDD, 4'hF, 8'd39, 3'd0);
    #1 chk("st_pop", pop_st_o, 1);
    tick();
    valid_i = 0; lsu_ctrl_i = '0; dtlb_hit_i = 0;
    #1 chk("st_valid", valid_o, 1); chk("st_tid", trans_id_o, 0);
    tick();
    commit_i = 1;
    tick();
    commit_i = 0; req_port_i[34] = 1;
    #1 chk("st_req", req_port_o[9], 1); chk("st_index", req_port_o[76:65], 12'h679);
    chk("st_tag", req_port_o[64:43], 22'h12345); chk("st_wdata", req_port_o[42:11], 32'hBBCCDDAA);
    chk("st_size", req_port_o[3:2], 2);
    tick();
    req_port_i[34] = 0;
    #1 chk("st_drained", {no_st_pending_o, store_buffer_empty_o}, 2'b11);
    tick();

    // Translation stall: three miss cycles then a hit
    valid_i = 1; paddr_i = 34'h1100; dtlb_hit_i = 0;
    lsu_ctrl_i = mk_lsu(32'h1100, 32'h11223344, 4'h3, 8'd42, 3'd5);
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_treq", translation_req_o, 1); chk("stall_pop", pop_st_o, 0);
      chk("stall_vaddr", vaddr_o, 32'h1100);
      tick();
      valid_i = 0; lsu_ctrl_i = mk_lsu(32'hDEAD0000, 32'h0, 4'h0, 8'd44, 3'd1);
    end
    dtlb_hit_i = 1;
    #1 chk("stall_hit_pop", pop_st_o, 1);
    tick();
    dtlb_hit_i = 0;
    #1 chk("stall_valid", valid_o, 1); chk("stall_tid", trans_id_o, 5);
    tick();
    commit_i = 1; tick();
    commit_i = 0; req_port_i[34] = 1; tick();
    req_port_i[34] = 0;

    // Fill the speculative queue; the fifth store waits for a commit
    valid_i = 1; dtlb_hit_i = 1;
    for (int i = 0; i < 5; i++) begin
      paddr_i = (i == 2) ? 34'h67C : 34'(32'h100 * (i + 1));
      lsu_ctrl_i = mk_lsu(paddr_i[31:0], $urandom, 4'hF, 8'd39, 3'(i));
      #1 chk("fill_pop", pop_st_o, i < 4);
      tick();
    end
    valid_i = 0; lsu_ctrl_i = '0; commit_i = 1;
    #1 chk("full_hold", pop_st_o, 0); chk("full_treq", translation_req_o, 1);
    tick();
    commit_i = 0;
    #1 chk("full_release", pop_st_o, 1);
    tick();
    dtlb_hit_i = 0;

    // Page-offset aliasing
    page_offset_i = 12'h67E;
    #1 chk("alias_hit", page_offset_matches_o, 1);
    tick();
    page_offset_i = 12'h680;
    #1 chk("alias_miss", page_offset_matches_o, 0);
    tick();

    // Drain, then flush with two speculative and one committed store
    commit_i = 1; req_port_i[34] = 1;
    for (int i = 0; i < 8; i++) tick();
    commit_i = 0; req_port_i[34] = 0;
    valid_i = 1; dtlb_hit_i = 1;
    for (int i = 0; i < 3; i++) begin
      paddr_i = 34'(32'h2000 + 32'h40 * i);
      lsu_ctrl_i = mk_lsu(paddr_i[31:0], $urandom, 4'hF, 8'd39, 3'(i));
      tick();
    end
    valid_i = 0; dtlb_hit_i = 0; commit_i = 1; tick();
    commit_i = 0; flush_i = 1; tick();
    flush_i = 0;
    #1 chk("flush_com_kept", no_st_pending_o, 0); chk("flush_index", req_port_o[76:65], 12'h000);
    chk("flush_spec_gone", page_offset_matches_o, 0);
    req_port_i[34] = 1; tick();
    req_port_i[34] = 0;
    #1 chk("flush_drained", store_buffer_empty_o, 1);
    tick();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rst_i      = ($urandom_range(0, 499) == 0);
      flush_i    = ($urandom_range(0, 39) == 0);
      valid_i    = ($urandom_range(0, 9) < 6);
      commit_i   = ($urandom_range(0, 99) < 35);
      dtlb_hit_i = ($urandom_range(0, 3) != 0);
      req_port_i = {($urandom_range(0, 9) < 4), 34'($urandom)};
      ex_i       = {$urandom, $urandom, ($urandom_range(0, 19) == 0)};
      paddr_i    = {22'($urandom), 8'h67, 4'($urandom)};
      page_offset_i = $urandom_range(0, 1) ? {8'h67, 4'($urandom)} : 12'($urandom);
      lsu_ctrl_i = mk_lsu($urandom, $urandom, 4'($urandom), ops[$urandom_range(0, 3)], 3'($urandom));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
